dma_bus_master: RTL and testbench

DMA_BUS_MASTER -- requirements
Module: dma_bus_master

---
 rtl/dma_bus_master.sv | 233 +++++++++++++++++++++++
 tb/tb_dma_bus_master.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_bus_master.sv
// dma_bus_master: programs a memory-mapped DMA engine over a simple
// single-cycle bus (SRC, DST, SIZE, then CSR), polls the CSR until DONE
// or ERROR, and reports the outcome on a one-cycle status pulse.
// Optional feature macro: DMA_MASTER_TIMEOUT_EN. When it is defined, polling
// stops after TIMEOUT_POLLS reads and the command reports sts_timeout.
// dma_pkg holds the register map and CSR bit positions.

package dma_pkg;
  localparam int unsigned REG_SRC   = 0;
  localparam int unsigned REG_DST   = 2;
  localparam int unsigned REG_SIZE  = 4;
  localparam int unsigned REG_CSR   = 6;
  localparam int unsigned CSR_GO    = 0;
  localparam int unsigned CSR_BUSY  = 1;
  localparam int unsigned CSR_DONE  = 2;
  localparam int unsigned CSR_ERROR = 3;
endpackage

module dma_bus_master
  import dma_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int ADDR_W        = 16,
  parameter int POLL_GAP      = 4,
  parameter int TIMEOUT_POLLS = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  // Command handshake: a command transfers on a rising clk edge where
  // cmd_valid and cmd_ready are both 1. cmd_ready is 1 only while idle and
  // out of reset; the fields are captured on that edge and ignored after.
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [DATA_W-1:0] cmd_size,
  output logic              bus_valid,
  output logic              bus_rnw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              sts_valid,
  output logic              sts_done,
  output logic              sts_error,
  output logic              sts_timeout,
  output logic [3:0]        dbg_state
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_SRC   = 4'd1,
    WR_DST   = 4'd2,
    WR_SIZE  = 4'd3,
    WR_CSR   = 4'd4,
    POLL_RD  = 4'd5,
    POLL_CAP = 4'd6,
    GAP      = 4'd7,
    REPORT   = 4'd8
  } state_t;

  localparam logic [ADDR_W-1:0] A_SRC  = ADDR_W'(REG_SRC);
  localparam logic [ADDR_W-1:0] A_DST  = ADDR_W'(REG_DST);
  localparam logic [ADDR_W-1:0] A_SIZE = ADDR_W'(REG_SIZE);
  localparam logic [ADDR_W-1:0] A_CSR  = ADDR_W'(REG_CSR);
  // GO and BUSY set, everything else (stale DONE/ERROR) cleared.
  localparam logic [DATA_W-1:0] CSR_START =
    DATA_W'((64'd1 << CSR_GO) | (64'd1 << CSR_BUSY));
  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD =
    (POLL_GAP > 0) ? GAP_W'(POLL_GAP - 1) : '0;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_dst;
  logic [DATA_W-1:0]   r_size;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic                r_bus_valid;
  logic                r_bus_rnw;
  logic [ADDR_W-1:0]   r_bus_addr;
  logic [DATA_W-1:0]   r_bus_wdata;
  logic                r_sts_valid;
  logic                r_sts_done;
  logic                r_sts_error;
  logic                r_sts_timeout;

  logic w_cap_done;
  logic w_cap_error;
  logic w_poll_exhausted;

  assign w_cap_done  = bus_rdata[CSR_DONE];
  assign w_cap_error = bus_rdata[CSR_ERROR];

`ifdef DMA_MASTER_TIMEOUT_EN
  localparam int PCNT_W = $clog2(TIMEOUT_POLLS + 1);
  logic [PCNT_W-1:0] r_poll_cnt;
  logic              w_poll_issue;

  // A poll is issued whenever the next state will be POLL_RD.
  assign w_poll_issue = (r_state == WR_CSR) ||
                        ((r_state == GAP) && (r_gap_cnt == '0)) ||
                        ((r_state == POLL_CAP) && !w_cap_error && !w_cap_done &&
                         !w_poll_exhausted && (POLL_GAP == 0));
  assign w_poll_exhausted = (r_poll_cnt >= PCNT_W'(TIMEOUT_POLLS));

  // Count CSR reads issued for the current command.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_poll_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_poll_cnt <= '0;
    end else if (w_poll_issue) begin
      r_poll_cnt <= r_poll_cnt + 1'b1;
    end
  end
`else
  assign w_poll_exhausted = 1'b0;
`endif

  // Main sequencer: state plus registered bus and status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= IDLE;
      r_dst         <= '0;
      r_size        <= '0;
      r_gap_cnt     <= '0;
      r_bus_valid   <= 1'b0;
      r_bus_rnw     <= 1'b0;
      r_bus_addr    <= '0;
      r_bus_wdata   <= '0;
      r_sts_valid   <= 1'b0;
      r_sts_done    <= 1'b0;
      r_sts_error   <= 1'b0;
      r_sts_timeout <= 1'b0;
    end else begin
      r_bus_valid <= 1'b0;
      r_bus_rnw   <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_sts_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_dst  <= cmd_dst;
            r_size <= cmd_size;
            if (cmd_size[0]) begin
              r_state       <= REPORT;
              r_sts_valid   <= 1'b1;
              r_sts_done    <= 1'b0;
              r_sts_error   <= 1'b1;
              r_sts_timeout <= 1'b0;
            end else begin
              r_state     <= WR_SRC;
              r_bus_valid <= 1'b1;
              r_bus_addr  <= A_SRC;
              r_bus_wdata <= DATA_W'(cmd_src);
            end
          end
        end
        WR_SRC: begin
          r_state     <= WR_DST;
          r_bus_valid <= 1'b1;
          r_bus_addr  <= A_DST;
          r_bus_wdata <= DATA_W'(r_dst);
        end
        WR_DST: begin
          r_state     <= WR_SIZE;
          r_bus_valid <= 1'b1;
          r_bus_addr  <= A_SIZE;
          r_bus_wdata <= r_size;
        end
        WR_SIZE: begin
          r_state     <= WR_CSR;
          r_bus_valid <= 1'b1;
          r_bus_addr  <= A_CSR;
          r_bus_wdata <= CSR_START;
        end
        WR_CSR: begin
          r_state     <= POLL_RD;
          r_bus_valid <= 1'b1;
          r_bus_rnw   <= 1'b1;
          r_bus_addr  <= A_CSR;
        end
        POLL_RD: begin
          r_state <= POLL_CAP;
        end
        POLL_CAP: begin
          if (w_cap_error || w_cap_done || w_poll_exhausted) begin
            r_state       <= REPORT;
            r_sts_valid   <= 1'b1;
            r_sts_error   <= w_cap_error;
            r_sts_done    <= w_cap_done && !w_cap_error;
            r_sts_timeout <= !w_cap_error && !w_cap_done;
          end else if (POLL_GAP == 0) begin
            r_state     <= POLL_RD;
            r_bus_valid <= 1'b1;
            r_bus_rnw   <= 1'b1;
            r_bus_addr  <= A_CSR;
          end else begin
            r_state   <= GAP;
            r_gap_cnt <= GAP_LOAD;
          end
        end
        GAP: begin
          if (r_gap_cnt == '0) begin
            r_state     <= POLL_RD;
            r_bus_valid <= 1'b1;
            r_bus_rnw   <= 1'b1;
            r_bus_addr  <= A_CSR;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        REPORT: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = rstn && (r_state == IDLE);
  assign bus_valid   = r_bus_valid;
  assign bus_rnw     = r_bus_rnw;
  assign bus_addr    = r_bus_addr;
  assign bus_wdata   = r_bus_wdata;
  assign sts_valid   = r_sts_valid;
  assign sts_done    = r_sts_done;
  assign sts_error   = r_sts_error;
  assign sts_timeout = r_sts_timeout;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_dma_bus_master.sv
// Bench for dma_bus_master with a behavioural DMA responder: 256-byte
// memory, DONE after size/2 cycles, ERROR when dst+size runs past the end.
module tb_dma_bus_master;

  localparam int BUDGET = 100;

  logic        clk;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_src;
  logic [15:0] cmd_dst;
  logic [15:0] cmd_size;
  logic        bus_valid;
  logic        bus_rnw;
  logic [15:0] bus_addr;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;
  logic        sts_valid;
  logic        sts_done;
  logic        sts_error;
  logic        sts_timeout;
  logic [3:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // observations of the last command
  logic [31:0] wr_q[$];
  int          wr_cyc_q[$];
  int          rd_cyc_q[$];
  logic [31:0] exp_q[$];
  int          sts_cycle;
  logic        got_done, got_error, got_timeout;
  logic        ready_at_issue;
  logic        post_valid, post_done, post_error, post_ready;

  // responder state
  logic [15:0] m_dst, m_size, m_csr;
  int          m_cnt;
  bit          never_done = 1'b0;

  dma_bus_master #(
    .DATA_W(16), .ADDR_W(16), .POLL_GAP(4), .TIMEOUT_POLLS(4)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_size(cmd_size),
    .bus_valid(bus_valid), .bus_rnw(bus_rnw), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .sts_valid(sts_valid), .sts_done(sts_done), .sts_error(sts_error),
    .sts_timeout(sts_timeout), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DMA responder model
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_dst <= 16'h0; m_size <= 16'h0; m_csr <= 16'h0; m_cnt <= 0;
      bus_rdata <= 16'h0;
    end else begin
      if (bus_valid && !bus_rnw) begin
        case (bus_addr)
          16'h0002: m_dst <= bus_wdata;
          16'h0004: m_size <= bus_wdata;
          16'h0006: begin
            if (bus_wdata[0]) begin
              if (never_done) m_csr <= bus_wdata;
              else if ({1'b0, m_dst} + {1'b0, m_size} > 17'd256) m_csr <= 16'h0008;
              else if (m_size < 16'd2) m_csr <= 16'h0004;
              else begin m_csr <= bus_wdata; m_cnt <= int'(m_size) / 2; end
            end else begin
              m_csr <= bus_wdata;
            end
          end
          default: ;
        endcase
      end else if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) m_csr <= 16'h0004;
      end
      if (bus_valid && bus_rnw) bus_rdata <= m_csr;
    end
  end

  // driver: issue one command, record bus traffic and the status pulse
  task automatic run_cmd(input logic [15:0] src, input logic [15:0] dst,
                         input logic [15:0] size);
    wr_q.delete(); wr_cyc_q.delete(); rd_cyc_q.delete();
    sts_cycle = -1; got_done = 1'b0; got_error = 1'b0; got_timeout = 1'b0;
    @(negedge clk);
    ready_at_issue = cmd_ready;
    cmd_valid = 1'b1; cmd_src = src; cmd_dst = dst; cmd_size = size;
    @(posedge clk);
    for (int c = 1; c <= BUDGET && sts_cycle < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cmd_valid = 1'b0; cmd_src = 16'hDEAD; cmd_dst = 16'hBEEF; cmd_size = 16'h0102;
      end
      if (bus_valid && !bus_rnw) begin
        wr_q.push_back({bus_addr, bus_wdata}); wr_cyc_q.push_back(c);
      end
      if (bus_valid && bus_rnw && bus_addr == 16'h0006) rd_cyc_q.push_back(c);
      if (sts_valid) begin
        sts_cycle = c; got_done = sts_done; got_error = sts_error; got_timeout = sts_timeout;
      end
    end
    @(negedge clk);
    post_valid = sts_valid; post_done = sts_done; post_error = sts_error; post_ready = cmd_ready;
  endtask

  task automatic test_reset;
    rstn = 1'b0; cmd_valid = 1'b0; cmd_src = 16'h0; cmd_dst = 16'h0; cmd_size = 16'h0;
    #1;
    checks++;
    if ({bus_valid, bus_rnw, bus_addr, bus_wdata} !== 34'h0) begin
      errors++; $display("FAIL reset_bus got v=%b rnw=%b a=%h d=%h exp all 0", bus_valid, bus_rnw, bus_addr, bus_wdata);
    end
    checks++;
    if ({sts_valid, sts_done, sts_error, sts_timeout, cmd_ready} !== 5'b0) begin
      errors++; $display("FAIL reset_sts got %b exp 00000", {sts_valid, sts_done, sts_error, sts_timeout, cmd_ready});
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || dbg_state !== 4'd0) begin
      errors++; $display("FAIL reset_release got ready=%b state=%0d exp ready=1 state=0", cmd_ready, dbg_state);
    end
  endtask

  task automatic test_basic;
    run_cmd(16'h0010, 16'h0040, 16'd8);
    exp_q.delete();
    exp_q.push_back(32'h0000_0010); exp_q.push_back(32'h0002_0040);
    exp_q.push_back(32'h0004_0008); exp_q.push_back(32'h0006_0003);
    checks++;
    if (ready_at_issue !== 1'b1) begin errors++; $display("FAIL basic_ready got %b exp 1", ready_at_issue); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= wr_q.size()) begin
        errors++; $display("FAIL basic_wr%0d got none exp %h", i, exp_q[i]);
      end else if (wr_q[i] !== exp_q[i] || wr_cyc_q[i] !== i + 1) begin
        errors++; $display("FAIL basic_wr%0d got %h @%0d exp %h @%0d", i, wr_q[i], wr_cyc_q[i], exp_q[i], i + 1);
      end
    end
    checks++;
    if (wr_q.size() !== 4) begin errors++; $display("FAIL basic_wr_count got %0d exp 4", wr_q.size()); end
    checks++;
    if (rd_cyc_q.size() !== 2 || rd_cyc_q[0] !== 5 || rd_cyc_q[1] !== 11) begin
      errors++; $display("FAIL basic_reads got count %0d exp 2 at cycles 5,11", rd_cyc_q.size());
    end
    checks++;
    if (sts_cycle !== 13) begin errors++; $display("FAIL basic_sts_cycle got %0d exp 13", sts_cycle); end
    checks++;
    if ({got_done, got_error, got_timeout} !== 3'b100) begin
      errors++; $display("FAIL basic_flags got d/e/t %b exp 100", {got_done, got_error, got_timeout});
    end
    checks++;
    if (post_valid !== 1'b0 || post_done !== 1'b1 || post_ready !== 1'b1) begin
      errors++; $display("FAIL basic_after got valid=%b done=%b ready=%b exp 0 1 1", post_valid, post_done, post_ready);
    end
  endtask

  task automatic test_size0;
    run_cmd(16'h0020, 16'h0080, 16'd0);
    exp_q.delete();
    exp_q.push_back(32'h0000_0020); exp_q.push_back(32'h0002_0080);
    exp_q.push_back(32'h0004_0000); exp_q.push_back(32'h0006_0003);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= wr_q.size()) begin
        errors++; $display("FAIL size0_wr%0d got none exp %h", i, exp_q[i]);
      end else if (wr_q[i] !== exp_q[i] || wr_cyc_q[i] !== i + 1) begin
        errors++; $display("FAIL size0_wr%0d got %h @%0d exp %h @%0d", i, wr_q[i], wr_cyc_q[i], exp_q[i], i + 1);
      end
    end
    checks++;
    if (rd_cyc_q.size() !== 1 || rd_cyc_q[0] !== 5) begin
      errors++; $display("FAIL size0_reads got count %0d exp 1 at cycle 5", rd_cyc_q.size());
    end
    checks++;
    if (sts_cycle !== 7 || got_done !== 1'b1 || got_error !== 1'b0) begin
      errors++; $display("FAIL size0_sts got cycle %0d d=%b e=%b exp cycle 7 d=1 e=0", sts_cycle, got_done, got_error);
    end
  endtask

  task automatic test_odd;
    run_cmd(16'h0030, 16'h0050, 16'd3);
    checks++;
    if (wr_q.size() !== 0 || rd_cyc_q.size() !== 0) begin
      errors++; $display("FAIL odd_bus got %0d writes %0d reads exp 0 0", wr_q.size(), rd_cyc_q.size());
    end
    checks++;
    if (sts_cycle !== 1 || {got_done, got_error, got_timeout} !== 3'b010) begin
      errors++; $display("FAIL odd_sts got cycle %0d d/e/t %b exp cycle 1 010", sts_cycle, {got_done, got_error, got_timeout});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sts_valid !== 1'b0 || sts_error !== 1'b1 || sts_done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL odd_hold got v=%b e=%b d=%b ready=%b exp 0 1 0 1", sts_valid, sts_error, sts_done, cmd_ready);
    end
  endtask

  task automatic test_dma_error;
    run_cmd(16'h0000, 16'h00F8, 16'd16);
    checks++;
    if (wr_q.size() !== 4 || wr_q[1] !== 32'h0002_00F8 || wr_q[2] !== 32'h0004_0010) begin
      errors++; $display("FAIL err_writes got count %0d exp 4 with dst 00f8 size 0010", wr_q.size());
    end
    checks++;
    if (sts_cycle !== 7 || {got_done, got_error, got_timeout} !== 3'b010) begin
      errors++; $display("FAIL err_sts got cycle %0d d/e/t %b exp cycle 7 010", sts_cycle, {got_done, got_error, got_timeout});
    end
  endtask

  task automatic test_back_to_back;
    run_cmd(16'h0004, 16'h0008, 16'd0);
    run_cmd(16'h0006, 16'h000A, 16'd2);
    checks++;
    if (ready_at_issue !== 1'b1 || wr_q.size() !== 4 || wr_q[0] !== 32'h0000_0006) begin
      errors++; $display("FAIL b2b_accept got ready=%b writes=%0d exp ready=1 writes=4", ready_at_issue, wr_q.size());
    end
    checks++;
    if (sts_cycle !== 13 || got_done !== 1'b1) begin
      errors++; $display("FAIL b2b_sts got cycle %0d done=%b exp cycle 13 done=1", sts_cycle, got_done);
    end
  endtask

`ifdef DMA_MASTER_TIMEOUT_EN
  task automatic test_timeout;
    never_done = 1'b1;
    run_cmd(16'h0000, 16'h0010, 16'd4);
    never_done = 1'b0;
    checks++;
    if (rd_cyc_q.size() !== 4) begin errors++; $display("FAIL timeout_reads got %0d exp 4", rd_cyc_q.size()); end
    checks++;
    if (sts_cycle !== 25 || {got_done, got_error, got_timeout} !== 3'b001) begin
      errors++; $display("FAIL timeout_sts got cycle %0d d/e/t %b exp cycle 25 001", sts_cycle, {got_done, got_error, got_timeout});
    end
  endtask
`endif

  task automatic test_reset_gap;
    int bad;
    never_done = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_src = 16'h0012; cmd_dst = 16'h0034; cmd_size = 16'd4;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) cmd_valid = 1'b0;
    end
    checks++;
    if (dbg_state !== 4'd7) begin errors++; $display("FAIL gap_state got %0d exp 7", dbg_state); end
    rstn = 1'b0;
    #1;
    checks++;
    if (bus_valid !== 1'b0 || cmd_ready !== 1'b0 || dbg_state !== 4'd0) begin
      errors++; $display("FAIL gap_reset got v=%b ready=%b state=%0d exp 0 0 0", bus_valid, cmd_ready, dbg_state);
    end
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus_valid || sts_valid) bad++;
    end
    rstn = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL gap_release got ready=%b exp 1", cmd_ready); end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus_valid || sts_valid) bad++;
    end
    checks++;
    if (bad !== 0 || sts_done !== 1'b0) begin
      errors++; $display("FAIL gap_quiet got %0d activity cycles done=%b exp 0 0", bad, sts_done);
    end
    never_done = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_size0;
    test_odd;
    test_dma_error;
    test_back_to_back;
`ifdef DMA_MASTER_TIMEOUT_EN
    test_timeout;
`endif
    test_reset_gap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
